move_select: RTL and testbench

MOVE_SELECT -- requirements
Module: move_select

---
 rtl/move_select_if.sv | 13 +
 rtl/move_select.sv | 163 ++++++++++++++++
 tb/tb_move_select.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_select_if.sv
// UI-side port bundle for move_select: cursor, select/cancel strobes and the move result.
// select/cancel are single-cycle strobes sampled on clk; moved is a one-cycle valid qualifying output_packet, with no backpressure.
interface move_select_if;
    logic [2:0]  cursor_x;
    logic [2:0]  cursor_y;
    logic        select;
    logic        cancel;
    logic        moved;
    logic [11:0] output_packet;

    modport master (output cursor_x, cursor_y, select, cancel, input moved, output_packet);
    modport slave  (input cursor_x, cursor_y, select, cancel, output moved, output_packet);
endinterface

// File: rtl/move_select.sv
// Source/destination move picker: validates cursor selects against the committed board and emits one move packet.
// Optional capture counter enabled by defining MOVE_SELECT_CAPTURE_CNT_EN.
module move_select #(
    parameter logic [3:0] EMPTY_CODE = 4'd15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    move_select_if.slave          ui,
    input  logic [7:0][7:0][3:0]  stable_board,
    input  logic                  player,
    input  logic                  curr_player,
    input  logic                  override,
    output logic [7:0][7:0][3:0]  disp_board,
    output logic                  src_valid,
    output logic [2:0]            src_x,
    output logic [2:0]            src_y,
    output logic                  sel_err,
    output logic [4:0]            cap_count,
    output logic [1:0]            state_dbg
);
    typedef enum logic [1:0] {
        WAIT_TURN = 2'd0,
        PICK_SRC  = 2'd1,
        PICK_DST  = 2'd2,
        COMMIT    = 2'd3
    } state_t;

    state_t state;

    function automatic logic is_own(input logic [3:0] code, input logic side);
        return side ? (code >= 4'd6 && code <= 4'd11) : (code <= 4'd5);
    endfunction

    function automatic logic [3:0] back_rank(input int col);
        case (col)
            0, 7:    return 4'd0;
            1, 6:    return 4'd1;
            2, 5:    return 4'd2;
            3:       return 4'd3;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [7:0][7:0][3:0] init_board();
        logic [7:0][7:0][3:0] b;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                b[r][c] = EMPTY_CODE;
            end
        end
        for (int c = 0; c < 8; c++) begin
            b[0][c] = back_rank(c);
            b[1][c] = 4'd5;
            b[6][c] = 4'd11;
            b[7][c] = back_rank(c) + 4'd6;
        end
        return b;
    endfunction

    logic [3:0]           cur_code;
    logic [3:0]           src_code;
    logic                 turn_ok;
    logic                 on_src;
    logic                 sel_only;
    logic                 commit_fire;
    logic [7:0][7:0][3:0] commit_board;

    assign cur_code    = stable_board[ui.cursor_y][ui.cursor_x];
    assign src_code    = stable_board[src_y][src_x];
    assign turn_ok     = (curr_player == player);
    assign on_src      = (ui.cursor_x == src_x) && (ui.cursor_y == src_y);
    assign sel_only    = ui.select && !ui.cancel;
    assign commit_fire = (state == PICK_DST) && turn_ok && !override && sel_only &&
                         !on_src && !is_own(cur_code, player);
    assign state_dbg   = state;

    // Source is vacated first so a destination equal to it can never occur here (on_src is excluded).
    always_comb begin
        commit_board = stable_board;
        commit_board[src_y][src_x] = EMPTY_CODE;
        commit_board[ui.cursor_y][ui.cursor_x] = src_code;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= WAIT_TURN;
            ui.moved         <= 1'b0;
            sel_err          <= 1'b0;
            src_valid        <= 1'b0;
            src_x            <= 3'd0;
            src_y            <= 3'd0;
            ui.output_packet <= 12'd0;
            disp_board       <= init_board();
        end else begin
            ui.moved   <= 1'b0;
            sel_err    <= 1'b0;
            disp_board <= stable_board;
            if (override) begin
                state     <= WAIT_TURN;
                src_valid <= 1'b0;
            end else begin
                case (state)
                    WAIT_TURN: begin
                        if (turn_ok) state <= PICK_SRC;
                    end
                    PICK_SRC: begin
                        if (!turn_ok) begin
                            state <= WAIT_TURN;
                        end else if (sel_only) begin
                            if (is_own(cur_code, player)) begin
                                src_x     <= ui.cursor_x;
                                src_y     <= ui.cursor_y;
                                src_valid <= 1'b1;
                                state     <= PICK_DST;
                            end else begin
                                sel_err <= 1'b1;
                            end
                        end
                    end
                    PICK_DST: begin
                        if (!turn_ok || ui.cancel) begin
                            src_valid <= 1'b0;
                            state     <= turn_ok ? PICK_SRC : WAIT_TURN;
                        end else if (ui.select) begin
                            if (on_src) begin
                                src_valid <= 1'b0;
                                state     <= PICK_SRC;
                            end else if (is_own(cur_code, player)) begin
                                src_x <= ui.cursor_x;
                                src_y <= ui.cursor_y;
                            end else begin
                                ui.output_packet <= {src_x, src_y, ui.cursor_x, ui.cursor_y};
                                disp_board       <= commit_board;
                                ui.moved         <= 1'b1;
                                state            <= COMMIT;
                            end
                        end
                    end
                    COMMIT: begin
                        src_valid <= 1'b0;
                        state     <= WAIT_TURN;
                    end
                    default: state <= WAIT_TURN;
                endcase
            end
        end
    end

`ifdef MOVE_SELECT_CAPTURE_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_count <= 5'd0;
        end else if (override) begin
            cap_count <= 5'd0;
        end else if (commit_fire && cur_code != EMPTY_CODE && cap_count != 5'd31) begin
            cap_count <= cap_count + 5'd1;
        end
    end
`else
    assign cap_count = 5'd0;
`endif

endmodule

// File: tb/tb_move_select.sv
// Randomized scoreboard bench for move_select: a square-level model predicts packets, boards and capture counts.
module tb_move_select;
    localparam logic [3:0] EMPTY = 4'd15;
    typedef logic [7:0][7:0][3:0] board_t;

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    move_select_if ui();
    board_t     stable_board;
    board_t     disp_board;
    logic       player, curr_player, override;
    logic       src_valid, sel_err;
    logic [2:0] src_x, src_y;
    logic [4:0] cap_count;
    logic [1:0] state_dbg;

    move_select #(.EMPTY_CODE(EMPTY)) dut (
        .clk(clk), .reset_n(reset_n), .ui(ui),
        .stable_board(stable_board), .player(player), .curr_player(curr_player),
        .override(override), .disp_board(disp_board), .src_valid(src_valid),
        .src_x(src_x), .src_y(src_y), .sel_err(sel_err), .cap_count(cap_count),
        .state_dbg(state_dbg)
    );

    // scoreboard
    logic [11:0] exp_q[$];
    board_t      exp_board_q[$];
    logic [4:0]  exp_cap_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    // model state
    bit         m_have;
    logic [2:0] m_sx, m_sy;
    int         m_cap;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic board_t start_layout();
        board_t b;
        int back[8] = '{0, 1, 2, 3, 4, 2, 1, 0};
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = (r == 1) ? 4'd5 : (r == 6) ? 4'd11 :
                          (r == 0) ? 4'(back[c]) : (r == 7) ? 4'(back[c] + 6) : EMPTY;
        return b;
    endfunction

    function automatic board_t random_board();
        board_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                int k = $urandom_range(0, 9);
                b[r][c] = (k < 4) ? EMPTY : (k < 7) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(6, 11));
            end
        return b;
    endfunction

    function automatic bit owns(input logic [3:0] code, input logic side);
        return (code < 4'd12) && ((code >= 4'd6) == side);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // driver: one select strobe, then model update and direct output checks
    task automatic do_select(input logic [2:0] x, input logic [2:0] y, input bit c);
        bit exp_err = 0;
        bit committed = 0;
        logic [3:0] code;
        ui.cursor_x = x;
        ui.cursor_y = y;
        ui.select = 1'b1;
        ui.cancel = c;
        @(posedge clk);
        #1;
        ui.select = 1'b0;
        ui.cancel = 1'b0;
        code = stable_board[y][x];
        if (!m_have) begin
            if (!c) begin
                if (owns(code, player)) begin
                    m_have = 1; m_sx = x; m_sy = y;
                end else begin
                    exp_err = 1;
                end
            end
        end else if (c || (x == m_sx && y == m_sy)) begin
            m_have = 0;
        end else if (owns(code, player)) begin
            m_sx = x; m_sy = y;
        end else begin
            board_t b = stable_board;
            b[m_sy][m_sx] = EMPTY;
            b[y][x] = stable_board[m_sy][m_sx];
            if (code != EMPTY && m_cap < 31) m_cap++;
            exp_q.push_back({m_sx, m_sy, x, y});
            exp_board_q.push_back(b);
`ifdef MOVE_SELECT_CAPTURE_CNT_EN
            exp_cap_q.push_back(5'(m_cap));
`else
            exp_cap_q.push_back(5'd0);
`endif
            m_have = 0;
            committed = 1;
        end
        @(negedge clk);
        check("sel_err", sel_err, exp_err);
        if (committed) begin
            tick(2);
            check("src_valid_after_commit", src_valid, 1'b0);
        end else begin
            check("src_valid", src_valid, m_have);
            if (m_have) check("src_xy", {src_x, src_y}, {m_sx, m_sy});
        end
    endtask

    task automatic pulse_override();
        override = 1'b1;
        @(posedge clk);
        #1;
        override = 1'b0;
        m_have = 0;
        m_cap = 0;
        @(negedge clk);
        check("override_src_valid", src_valid, 1'b0);
        tick(1);
    endtask

    task automatic load_board(input board_t b);
        stable_board = b;
        tick(2);
        check("disp_copy", disp_board, b);
    endtask

    // monitor: pop expected move on every moved pulse
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && ui.moved) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL moved_unexpected: got packet %0h expected no move", ui.output_packet);
                end else begin
                    e = exp_q.pop_front();
                    check("packet", ui.output_packet, e);
                    check("commit_board", disp_board, exp_board_q.pop_front());
                    check("cap_count", cap_count, exp_cap_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        ui.cursor_x = 3'd0; ui.cursor_y = 3'd0; ui.select = 1'b0; ui.cancel = 1'b0;
        stable_board = start_layout();
        player = 1'b0; curr_player = 1'b0; override = 1'b0;
        m_have = 0; m_cap = 0; m_sx = 0; m_sy = 0;

        #12;
        check("rst_moved", ui.moved, 1'b0);
        check("rst_sel_err", sel_err, 1'b0);
        check("rst_src_valid", src_valid, 1'b0);
        check("rst_src_xy", {src_x, src_y}, 6'd0);
        check("rst_packet", ui.output_packet, 12'd0);
        check("rst_cap", cap_count, 5'd0);
        check("rst_board", disp_board, start_layout());
        @(negedge clk);
        reset_n = 1'b1;
        tick(2);

        // basic move, then rejected source select
        do_select(3'd1, 3'd0, 0);
        do_select(3'd2, 3'd2, 0);
        do_select(3'd4, 3'd4, 0);

        // relatch then select+cancel together
        do_select(3'd1, 3'd0, 0);
        do_select(3'd6, 3'd0, 0);
        do_select(3'd3, 3'd3, 1);
        check("no_move_pending", exp_q.size(), 0);

        // override aborts a held source; wrong side to move keeps waiting
        do_select(3'd1, 3'd0, 0);
        pulse_override();
        curr_player = 1'b1;
        tick(1);
        ui.cursor_x = 3'd4; ui.cursor_y = 3'd4; ui.select = 1'b1;
        @(posedge clk); #1 ui.select = 1'b0;
        @(negedge clk);
        check("wait_select_no_err", sel_err, 1'b0);
        check("wait_src_valid", src_valid, 1'b0);
        curr_player = 1'b0;
        tick(2);

        // losing the turn mid-selection
        do_select(3'd5, 3'd1, 0);
        curr_player = 1'b1;
        @(negedge clk);
        check("turn_loss_src_valid", src_valid, 1'b0);
        m_have = 0;
        curr_player = 1'b0;
        tick(2);

        // capture onto code 11, then a quiet move
        do_select(3'd0, 3'd1, 0);
        do_select(3'd0, 3'd6, 0);
        do_select(3'd1, 3'd1, 0);
        do_select(3'd1, 3'd3, 0);

        // asynchronous reset while a source is held
        do_select(3'd2, 3'd1, 0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_src_valid", src_valid, 1'b0);
        check("arst_src_xy", {src_x, src_y}, 6'd0);
        check("arst_packet", ui.output_packet, 12'd0);
        check("arst_cap", cap_count, 5'd0);
        check("arst_board", disp_board, start_layout());
        @(negedge clk);
        reset_n = 1'b1;
        m_have = 0; m_cap = 0;
        tick(1);
        do_select(3'd3, 3'd1, 0);
        do_select(3'd3, 3'd3, 0);

        // randomized games
        load_board(random_board());
        for (int i = 0; i < 300; i++) begin
            logic [2:0] x, y;
            bit c = 0;
            x = 3'($urandom_range(0, 7));
            y = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                for (int t = 0; t < 16; t++) begin
                    logic [2:0] rx = 3'($urandom_range(0, 7));
                    logic [2:0] ry = 3'($urandom_range(0, 7));
                    if (owns(stable_board[ry][rx], player)) begin
                        x = rx; y = ry;
                        break;
                    end
                end
            end
            if (m_have) begin
                if ($urandom_range(0, 9) == 0) c = 1;
                else if ($urandom_range(0, 7) == 0) begin x = m_sx; y = m_sy; end
            end
            do_select(x, y, c);
            if (!m_have && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 9) == 0) pulse_override();
                player = 1'($urandom_range(0, 1));
                curr_player = player;
                load_board(random_board());
            end
        end

        tick(3);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
